// File: rtl/altera_ddr_ex_lfsr_seq_pkg.sv
// Shared constants and the LFSR next-state function for the DDR example
// pattern sequencer.
package altera_ddr_ex_pkg;

  localparam int unsigned LFSR_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] ERR_SAT = 8'd255;

  // Galois step, feedback from bit 7 into bits 0, 2, 3 and 4.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] d);
    return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
  endfunction

endpackage

// File: rtl/altera_ddr_ex_lfsr_seq_lfsr8.sv
// 8-bit Galois LFSR: reseeds to SEED while disabled, loads ldata on load,
// otherwise steps unless paused.
module altera_ddr_ex_lfsr8
  import altera_ddr_ex_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              load,
  input  logic              pause,
  input  logic [LFSR_W-1:0] ldata,
  output logic [LFSR_W-1:0] data
);

  logic [LFSR_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (!enable) begin
      data_d = SEED;
    end else if (load) begin
      data_d = ldata;
    end else if (!pause) begin
      data_d = lfsr_step(data_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= SEED;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/altera_ddr_ex_lfsr_seq.sv
// Write/read-back LFSR pattern sequencer for the DDR example driver:
// streams a seeded byte burst out, then regenerates and checks it on return.
module altera_ddr_ex_lfsr_seq
  import altera_ddr_ex_pkg::*;
#(
  parameter int unsigned SEED = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] start_seed,
  input  logic [7:0] burst_len,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_data,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_err_idx
);

  localparam logic [7:0] SEED8 = 8'(SEED);

  logic [1:0] state_q, state_d;
  logic [7:0] seed_q, seed_d;
  logic [8:0] len_q, len_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] err_q, err_d;
  logic [7:0] fidx_q, fidx_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;

  logic       lfsr_en, lfsr_ld, lfsr_pause;
  logic [7:0] lfsr_ldata, lfsr_data, eff_seed;
  logic       last, reset_n;

  assign reset_n  = ~reset;
  assign eff_seed = (start_seed == 8'd0) ? SEED8 : start_seed;
  assign last     = (cnt_q == (len_q - 9'd1));

  altera_ddr_ex_lfsr8 #(.SEED(SEED8)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (lfsr_en),
    .load    (lfsr_ld),
    .pause   (lfsr_pause),
    .ldata   (lfsr_ldata),
    .data    (lfsr_data)
  );

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fidx_d     = fidx_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    lfsr_en    = 1'b0;
    lfsr_ld    = 1'b0;
    lfsr_pause = 1'b1;
    lfsr_ldata = seed_q;

    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            seed_d     = eff_seed;
            len_d      = {burst_len == 8'd0, burst_len};
            cnt_d      = '0;
            err_d      = '0;
            fidx_d     = '0;
            pass_d     = 1'b0;
            lfsr_en    = 1'b1;
            lfsr_ld    = 1'b1;
            lfsr_ldata = eff_seed;
            state_d    = ST_WRITE;
          end
        end
        ST_WRITE: begin
          lfsr_en    = 1'b1;
          lfsr_pause = !wr_ready;
          if (wr_ready) begin
            if (last) begin
              // Rewind to the seed so READ regenerates the same stream.
              lfsr_ld = 1'b1;
              cnt_d   = '0;
              state_d = ST_READ;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
        end
        ST_READ: begin
          lfsr_en    = 1'b1;
          lfsr_pause = !rd_valid;
          if (rd_valid) begin
            cnt_d = cnt_q + 9'd1;
            if (rd_data != lfsr_data) begin
              if (err_q != ERR_SAT) err_d = err_q + 8'd1;
              if (err_q == 8'd0) fidx_d = cnt_q[7:0];
            end
            if (last) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = (err_d == 8'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign wr_valid      = (state_q == ST_WRITE);
  assign busy          = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign wr_data       = lfsr_data;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_altera_ddr_ex_lfsr_seq.sv
// Scoreboard bench for the LFSR write/read-back sequencer.
module tb_altera_ddr_ex_lfsr_seq;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] start_seed, burst_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, done, pass;
  logic [7:0] err_count, first_err_idx;

  typedef struct {
    logic       pass;
    logic [7:0] errc;
    logic [7:0] fidx;
  } res_t;

  logic [7:0] wr_q[$];
  res_t       res_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  altera_ddr_ex_lfsr_seq #(.SEED(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .start_seed    (start_seed),
    .burst_len     (burst_len),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] v);
    logic [7:0] n;
    n = {v[6:0], 1'b0};
    if (v[7]) n = n ^ 8'h1D;
    return n;
  endfunction

  // Output side of the scoreboard: write handshakes and done pulses.
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      if (wr_q.size() == 0) check("wr_extra", 1, 0);
      else check("wr_data", wr_data, wr_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      if (res_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("pass", pass, r.pass);
        check("err_count", err_count, r.errc);
        check("first_err_idx", first_err_idx, r.fidx);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_err_idx"}, first_err_idx, 0);
    check({tag, "_wr_data"}, wr_data, 8'h20);
  endtask

  // kill: 0 = full test, 1 = restart attempt + abort in WRITE, 2 = reset in READ
  task automatic run_test(input logic [7:0] s, input logic [7:0] l, input int ready_mode,
                          input int gap, input int corrupt, input int kill);
    logic [7:0] exp_b[256];
    logic [7:0] v, eff;
    int         len, errs, first, cyc, i, d0;
    logic       bad;
    res_t       r;

    eff   = (s == 8'd0) ? 8'h20 : s;
    len   = (l == 8'd0) ? 256 : int'(l);
    v     = eff;
    errs  = 0;
    first = -1;
    for (int k = 0; k < len; k++) begin
      exp_b[k] = v;
      wr_q.push_back(v);
      v = step(v);
      bad = (corrupt == 2) || (corrupt == 1 && (k == 3 || k == 5));
      if (bad) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    r.pass = (errs == 0);
    r.errc = (errs > 255) ? 8'd255 : 8'(errs);
    r.fidx = (first < 0) ? 8'd0 : 8'(first);
    res_q.push_back(r);
    d0 = done_cnt;

    start_seed = s;
    burst_len  = l;
    start      = 1'b1;
    wr_ready   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;

    cyc = 0;
    while (wr_q.size() != 0 && cyc < 3000) begin
      if (kill == 1 && cyc == 2) begin
        start = 1'b1; start_seed = 8'h77; burst_len = 8'd3;
      end
      if (kill == 1 && cyc == 3) start = 1'b0;
      if (kill == 1 && cyc == 5) begin
        abort = 1'b1; wr_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wr_q.delete();
        res_q.delete();
        check("abort_busy", busy, 0);
        check("abort_wr_valid", wr_valid, 0);
        check("abort_pass", pass, 0);
        check("abort_err_count", err_count, 0);
        check("abort_wr_data", wr_data, 8'h20);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", busy, 0);
        return;
      end
      wr_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check("wr_timeout", wr_q.size(), 0);
    check("reload_seed", wr_data, eff);
    check("rd_busy", busy, 1);
    check("wr_valid_drop", wr_valid, 0);
    wr_ready = 1'b1;

    cyc = 0;
    i   = 0;
    while (i < len && cyc < 3000) begin
      if (kill == 2 && cyc == 3) begin
        reset = 1'b1; rd_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; rd_valid = 1'b0;
        res_q.delete();
        check_reset_vals("rst_read");
        return;
      end
      rd_valid = (gap == 0) || (cyc % 2 == 0);
      if (rd_valid) begin
        bad = (corrupt == 2) || (corrupt == 1 && (i == 3 || i == 5));
        rd_data = exp_b[i] ^ (bad ? 8'h5A : 8'h00);
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_valid = 1'b0;
    wr_ready = 1'b0;

    cyc = 0;
    while (res_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_timeout", res_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("end_busy", busy, 0);
    check("pass_held", pass, r.pass);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    start_seed = '0; burst_len = '0;
    wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_test(8'h01, 8'd9,  0, 1, 0, 0);
    run_test(8'h00, 8'd12, 1, 0, 0, 0);
    run_test(8'hA5, 8'd10, 1, 1, 1, 0);
    run_test(8'h3C, 8'd0,  0, 0, 2, 0);
    run_test(8'h11, 8'd20, 0, 0, 0, 1);
    run_test(8'h11, 8'd9,  1, 1, 0, 0);
    run_test(8'h5E, 8'd16, 0, 0, 2, 2);
    run_test(8'h00, 8'd4,  0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/altera_ddr_ex_lfsr_seq.md
Name: altera_ddr_ex_lfsr_seq

Overview:
- Sequences one 8-bit LFSR pattern generator for the DDR example driver.
- Write phase: streams a burst of pseudo-random bytes to the write path.
- Read phase: reloads the starting seed, regenerates the identical sequence, and compares it against returned read data.
- Reports done, pass/fail, error count and first failing index to the example test status logic.

Parameters:
- SEED, 32, default LFSR seed. Used when start_seed = 0. Must be non-zero.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a test. Ignored unless in IDLE or DONE.
- abort  in  1  synchronous abort to IDLE.
- start_seed  in  8  seed for this test. 0 selects SEED.
- burst_len  in  8  bytes per phase. 0 means 256. Sampled on accepted start.
- wr_valid  out  1  write byte valid.
- wr_ready  in  1  write sink accepts the byte this cycle.
- wr_data  out  8  current LFSR value.
- rd_valid  in  1  read byte present. Sampled only in READ.
- rd_data  in  8  returned read byte.
- busy  out  1  high in WRITE or READ.
- done  out  1  one-cycle pulse at test completion.
- pass  out  1  high when the last completed test had zero errors. Held until the next accepted start.
- err_count  out  8  mismatch count, saturates at 255.
- first_err_idx  out  8  byte index of the first mismatch, low 8 bits. 0 if there were no errors.

Behaviour:
- Reset values: state = IDLE; wr_valid, busy, done, pass, err_count, first_err_idx, byte counter = 0. LFSR holds SEED.
- State IDLE:
  - LFSR enable = 0, so the LFSR reseeds to SEED every cycle.
  - On start: latch eff_seed = (start_seed == 0) ? SEED[7:0] : start_seed; latch len (9 bits, 0 maps to 256); clear err_count, first_err_idx, pass, cnt.
  - Same cycle: drive enable = 1, load = 1, ldata = eff_seed. Next cycle → WRITE with wr_data = eff_seed (0-cycle setup).
- State WRITE:
  - wr_valid = 1, busy = 1, wr_data = LFSR value.
  - LFSR pause = !(wr_valid & wr_ready). Data is held stable while the sink is not ready.
  - Each handshake increments cnt.
  - On the handshake with cnt == len-1: load = 1, ldata = eff_seed, cnt <= 0, → READ. wr_valid drops the next cycle.
- State READ:
  - busy = 1, wr_valid = 0, pause = !rd_valid.
  - Each rd_valid compares rd_data with the LFSR value and increments cnt.
  - On mismatch: err_count increments, saturating at 255. If err_count was 0, first_err_idx <= cnt[7:0].
  - On the rd_valid with cnt == len-1: → DONE. The final compare counts toward the result.
- State DONE:
  - done = 1 for exactly the entry cycle.
  - pass = (final err_count == 0), registered with done.
  - Then idle in DONE with busy = 0 and enable = 0. start is accepted exactly as in IDLE.
- abort: from any state, → IDLE next cycle. No done pulse; pass = 0; counters hold their values.
- Simultaneous events:
  - abort has priority over start and over handshakes.
  - reset has priority over everything.
- rd_valid outside READ and wr_ready outside WRITE: ignored, no count change.
- Zero seed is never loaded. The all-zero LFSR state is a lockup state.
- Counter width is 9 bits so len = 256 completes after exactly 256 bytes.
- LFSR step (Galois, taps at bits 2, 3, 4 from bit 7):
  - n[0] = d7, n[1] = d0, n[2] = d1^d7, n[3] = d2^d7, n[4] = d3^d7, n[5] = d4, n[6] = d5, n[7] = d6.

Decomposition:
- Shared package altera_ddr_ex_pkg:
  - state encoding constants ST_IDLE, ST_WRITE, ST_READ, ST_DONE.
  - LFSR width constant 8.
  - ERR_SAT = 255.
- One sub-module: instance of altera_ddr_ex_lfsr8 (seed = SEED).
  - Its reset_n is tied to ~reset; sequencing uses only enable, load and pause.
- The controller FSM and checker stay in this block.

Test Plan:
- Seed 0x01, len 9, wr_ready = 1 → wr_data 01,02,04,08,10,20,40,80,1D on consecutive cycles; wr_valid high for 9 cycles; LFSR reloads to 01.
- Same test, read back identical bytes with rd_valid gapped (1-0-1 pattern) → done pulse once; pass = 1; err_count = 0; first_err_idx = 0.
- start_seed = 0 → first wr_data = 0x20 (SEED), then 0x40, 0x80, 0x1D. wr_ready toggling → no byte skipped or repeated.
- Read phase corrupts bytes 3 and 5 → err_count = 2, first_err_idx = 3, pass = 0.
- burst_len = 0, all reads wrong → 256 writes, 256 reads; err_count saturates at 255; done asserted after the 256th read.
- abort mid-WRITE, and start asserted while busy → immediate IDLE, no done pulse, start ignored while busy. A later start runs a clean test. Reset mid-READ → all outputs at reset values next cycle.
